// File: rtl/if_id_skid_if.sv
// Fetch/decode beat channel: valid/ready handshake carrying pc, instruction, exception and
// delay-slot flag.
interface if_id_skid_if #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned EXC_W  = 4
);
   logic              valid;
   logic              ready;
   logic [PC_W-1:0]   pc;
   logic [INST_W-1:0] inst;
   logic [EXC_W-1:0]  exc;
   logic              ds;

   modport master (output valid, pc, inst, exc, ds, input ready);
   modport slave  (input valid, pc, inst, exc, ds, output ready);
endinterface

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with one-entry skid buffer; ready towards fetch is registered so
// decode backpressure never reaches fetch combinationally.
module if_id_skid #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned EXC_W  = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   if_id_skid_if.slave      in_ch,
   if_id_skid_if.master     out_ch,
   input  logic             flush,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam int unsigned BeatW = PC_W + INST_W + EXC_W + 1;

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e           state_q;
   logic             ready_q;
   logic             valid_q;
   logic [BeatW-1:0] main_q;
   logic [BeatW-1:0] skid_q;
   logic [CNT_W-1:0] cnt_q;
   logic [BeatW-1:0] in_beat;
   logic             in_xfer;
   logic             out_xfer;

   assign in_beat  = {in_ch.pc, in_ch.inst, in_ch.exc, in_ch.ds};
   assign in_xfer  = in_ch.valid & ready_q;
   assign out_xfer = valid_q & out_ch.ready;

   assign in_ch.ready  = ready_q;
   assign out_ch.valid = valid_q;
   assign {out_ch.pc, out_ch.inst, out_ch.exc, out_ch.ds} = main_q;
   assign stall_cnt = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         main_q  <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         // Stall counting ignores flush: a stalled beat still cost decode a cycle.
         if (valid_q && !out_ch.ready && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (flush) begin
            state_q <= StEmpty;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
         end else begin
            unique case (state_q)
               StEmpty: begin
                  if (in_xfer) begin
                     main_q  <= in_beat;
                     valid_q <= 1'b1;
                     state_q <= StOne;
                  end
               end
               StOne: begin
                  if (in_xfer && out_xfer) begin
                     main_q <= in_beat;
                  end else if (in_xfer) begin
                     skid_q  <= in_beat;
                     ready_q <= 1'b0;
                     state_q <= StFull;
                  end else if (out_xfer) begin
                     // Cleared fields present a NOP to decode while empty.
                     main_q  <= '0;
                     valid_q <= 1'b0;
                     state_q <= StEmpty;
                  end
               end
               StFull: begin
                  if (out_xfer) begin
                     main_q  <= skid_q;
                     skid_q  <= '0;
                     ready_q <= 1'b1;
                     state_q <= StOne;
                  end
               end
               default: begin
                  state_q <= StEmpty;
                  ready_q <= 1'b1;
                  valid_q <= 1'b0;
                  main_q  <= '0;
                  skid_q  <= '0;
               end
            endcase
         end
      end
   end
endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 Parameter PC_W, default 32, fetch-address width.
REQ-002 Parameter INST_W, default 32, instruction width.
REQ-003 Parameter EXC_W, default 4, fetch-exception sideband width.
REQ-004 Parameter CNT_W, default 16, stall-counter width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  fetch presents a beat.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_pc  input  PC_W  fetch address.
REQ-010 in_inst  input  INST_W  fetched instruction.
REQ-011 in_exc  input  EXC_W  fetch exception code; 0 = none.
REQ-012 in_ds  input  1  beat is a branch delay slot.
REQ-013 out_valid  output  1  decode beat valid.
REQ-014 out_ready  input  1  decode accepts beat.
REQ-015 out_pc / out_inst / out_exc / out_ds  output  PC_W / INST_W / EXC_W / 1  registered beat fields.
REQ-016 flush  input  1  discard all held and incoming beats (branch redirect, exception).
REQ-017 stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-018 Input transfer occurs when in_valid=1 and in_ready=1; output transfer occurs when out_valid=1 and out_ready=1.
REQ-019 Storage is a main register (drives outputs) plus one skid register; states EMPTY, ONE, FULL.
REQ-020 in_ready shall be a registered signal, 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-021 EMPTY: input transfer -> ONE, main loads input; otherwise stay EMPTY.
REQ-022 ONE: input and output transfer -> ONE, main loads input; input transfer only -> FULL, skid loads input; output transfer only -> EMPTY; neither -> hold.
REQ-023 FULL: output transfer -> ONE, main loads skid; otherwise hold, no field changes.
REQ-024 Latency: beat accepted in cycle N appears on outputs in cycle N+1 when block not FULL; throughput one beat per cycle with out_ready held 1.
REQ-025 Beats shall leave in acceptance order; no beat duplicated or dropped except by flush.
REQ-026 out_valid=1 exactly in ONE and FULL.
REQ-027 On entering EMPTY (output-only transfer or flush), out_pc, out_inst, out_exc, out_ds shall be cleared to 0 so decode sees a NOP (inst 0).
REQ-028 flush=1: next state EMPTY, skid invalidated, outputs cleared per REQ-027, in_ready=1 next cycle; a beat transferred in the flush cycle is discarded.
REQ-029 flush in the same cycle as an output transfer: the output beat counts as consumed; flush still empties the block.
REQ-030 stall_cnt increments by 1 each cycle with out_valid=1 and out_ready=0, saturates at 2^CNT_W-1, never wraps; unaffected by flush.
REQ-031 Fields are opaque: no interpretation of inst, pc or exc contents.

Reset
REQ-032 rst=1 at a rising edge: state EMPTY, out_valid=0, in_ready=1, all out_* fields 0, skid cleared, stall_cnt=0.
REQ-033 rst has priority over flush and all transfers; a beat presented during reset is discarded.
REQ-034 Reset mid-operation (ONE or FULL) discards held beats with no output transfer in that cycle.

Verification
REQ-035 Streaming: out_ready=1, beats pc=0x100,0x104,0x108 on consecutive cycles -> same beats on outputs one cycle later each, in_ready stays 1, stall_cnt=0.
REQ-036 Backpressure: out_ready=0 after beat 0x100 shown, send 0x104 -> FULL, in_ready=0 next cycle; release out_ready -> 0x100 then 0x104 delivered, stall_cnt equals stalled cycles.
REQ-037 Flush in FULL with in_valid=1 (pc 0x200) -> next cycle out_valid=0, out_inst=0, in_ready=1; 0x200 never appears.
REQ-038 Sideband: beat with in_exc=0x3, in_ds=1 -> out_exc=0x3, out_ds=1 with matching pc/inst.
REQ-039 Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-040 Reset while FULL -> next cycle out_valid=0, in_ready=1, all fields 0, stall_cnt=0.
